// File: rtl/mem_stage_sram_controller.sv
// mem_stage_sram_controller
//   Memory-stage responder for pipeline loads/stores. Each 32-bit word access
//   becomes two sequential 16-bit accesses on an external asynchronous SRAM.
//   The low halfword is accessed first, then the high halfword, then
//   WAIT_CYCLES idle cycles. ready is held low until the transaction finishes,
//   which freezes the pipeline.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, rd_en      store / load request (level, held until ready)
//   address           byte address; (address - MEM_BASE) >> 2 selects the word
//   write_data        store data
//   read_data         registered load result
//   ready             1 = idle with no request, or transaction completing
//   sram_addr         SRAM halfword address
//   sram_dq_out       data toward SRAM
//   sram_dq_oe        drive enable for sram_dq_out
//   sram_dq_in        data from SRAM
//   sram_we_n         SRAM write enable, active low
module mem_stage_sram_controller #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] MEM_BASE    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOW  = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Counter value on the last WAIT cycle; unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [2:0]  state;
    logic [3:0]  wait_cnt;
    logic        op_write;
    logic [16:0] word;
    logic [31:0] data;
    logic [16:0] word_in;

    assign word_in = 17'((address - MEM_BASE) >> 2);

    assign ready = (state == S_DONE) || ((state == S_IDLE) && !rd_en && !wr_en);

    // SRAM bus outputs are registered, so each state's bus values are loaded
    // on the edge that enters that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            op_write    <= 1'b0;
            word        <= '0;
            data        <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_en || wr_en) begin
                        // A write wins when both requests are raised.
                        op_write    <= wr_en;
                        word        <= word_in;
                        data        <= write_data;
                        sram_addr   <= {word_in, 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= !wr_en;
                        state       <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (!op_write) begin
                        read_data[15:0] <= sram_dq_in;
                    end
                    sram_addr   <= {word, 1'b1};
                    sram_dq_out <= data[31:16];
                    state       <= S_HIGH;
                end
                S_HIGH: begin
                    if (!op_write) begin
                        read_data[31:16] <= sram_dq_in;
                    end
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    state      <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_controller.sv
// Bench for mem_stage_sram_controller: a default instance (WAIT_CYCLES=3)
// backed by a small SRAM model, and a WAIT_CYCLES=0 instance reading a fixed
// address-derived pattern. Completions are checked by scoreboard monitors.
module tb_mem_stage_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    // default instance
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    // zero-wait instance
    logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
    logic [31:0] address1 = '0, write_data1 = '0;
    logic [31:0] read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1;
    logic        sram_dq_oe1;
    logic [15:0] sram_dq_in1;
    logic        sram_we_n1;

    typedef struct {
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1, en;
    int   start0 = 0, start1 = 0;

    logic [15:0] mem [0:63];

    mem_stage_sram_controller #(.WAIT_CYCLES(3), .MEM_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    mem_stage_sram_controller #(.WAIT_CYCLES(0), .MEM_BASE(32'd1024)) dut0w (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
        .address(address1), .write_data(write_data1), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
        .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: asynchronous read, write while we_n is low at a clock edge.
    assign sram_dq_in = mem[sram_addr[5:0]];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    assign sram_dq_in1 = 16'h1000 + sram_addr1[15:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Completion monitors: DONE is the only state with ready=1 and a request up.
    always @(negedge clk) begin
        if (!rst && ready && (rd_en || wr_en)) begin
            if (q0.size() == 0) begin
                chk("sb0_unexpected_done", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("sb0_read_data", read_data, e0.rd);
                chk("sb0_latency", 32'(cyc - start0), 32'(e0.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ready1 && (rd_en1 || wr_en1)) begin
            if (q1.size() == 0) begin
                chk("sb1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("sb1_read_data", read_data1, e1.rd);
                chk("sb1_latency", 32'(cyc - start1), 32'(e1.lat));
            end
        end
    end

    task automatic txn0(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic [17:0] lo);
        int k;
        logic [17:0] hi;
        hi = lo + 18'd1;
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        start0 = cyc;
        en.rd = exp_rd; en.lat = 6;
        q0.push_back(en);
        k = 0;
        forever begin
            @(negedge clk);
            if (wr) begin
                if (k == 1) begin
                    chk("wr_lo_addr", 32'(sram_addr), 32'(lo));
                    chk("wr_lo_dq", 32'(sram_dq_out), 32'(d[15:0]));
                    chk("wr_lo_we_n", 32'(sram_we_n), 32'd0);
                    chk("wr_lo_oe", 32'(sram_dq_oe), 32'd1);
                end else if (k == 2) begin
                    chk("wr_hi_addr", 32'(sram_addr), 32'(hi));
                    chk("wr_hi_dq", 32'(sram_dq_out), 32'(d[31:16]));
                    chk("wr_hi_we_n", 32'(sram_we_n), 32'd0);
                    chk("wr_hi_oe", 32'(sram_dq_oe), 32'd1);
                end else begin
                    chk("wr_idle_we_n", 32'(sram_we_n), 32'd1);
                end
            end else begin
                chk("rd_we_n", 32'(sram_we_n), 32'd1);
                chk("rd_oe", 32'(sram_dq_oe), 32'd0);
                if (k == 1) chk("rd_lo_addr", 32'(sram_addr), 32'(lo));
                if (k == 2) chk("rd_hi_addr", 32'(sram_addr), 32'(hi));
            end
            if (ready) break;
            k++;
            if (k > 40) begin
                chk("txn0_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic txn1_read(input logic [31:0] a, input logic [31:0] exp_rd);
        int k;
        @(posedge clk); #1;
        rd_en1 = 1'b1; address1 = a;
        start1 = cyc;
        en.rd = exp_rd; en.lat = 3;
        q1.push_back(en);
        k = 0;
        forever begin
            @(negedge clk);
            chk("w0_ready_profile", 32'(ready1), (k == 3) ? 32'd1 : 32'd0);
            if (ready1) break;
            k++;
            if (k > 40) begin
                chk("txn1_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        rd_en1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

        // reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_w0_ready", 32'(ready1), 32'd1);
        chk("rst_w0_we_n", 32'(sram_we_n1), 32'd1);

        // store, then load it back
        txn0(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h0000_0000, 18'd2);
        chk("mem2", 32'(mem[2]), 32'h0000BEEF);
        chk("mem3", 32'(mem[3]), 32'h0000DEAD);
        txn0(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 18'd2);

        // simultaneous read+write: only the write happens
        txn0(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 18'd0);
        chk("mem0", 32'(mem[0]), 32'h00005678);
        chk("mem1", 32'(mem[1]), 32'h00001234);
        txn0(1'b0, 1'b1, 32'd1024, 32'h0, 32'h12345678, 18'd0);

        // reset during HIGH of a write
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_hi_addr", 32'(sram_addr), 32'd5);
        chk("mid_hi_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("post_rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_read_data", read_data, 32'd0);
        txn0(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 18'd2);

        // zero-wait instance
        txn1_read(32'd1040, 32'h10091008);
        txn1_read(32'd1044, 32'h100B100A);

        repeat (3) @(posedge clk);
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_sram_controller.md
Name: mem_stage_sram_controller

Overview:
- Memory-stage responder for the load/store requests the decode/control path raises (mem_read/mem_write carried down the pipeline).
- Converts one 32-bit word access into two sequential 16-bit accesses on the external asynchronous SRAM.
- Holds ready low for the whole transaction so the pipeline freezes (hazard/freeze logic consumes ready).
- Data memory base address is 1024; addresses below it are not remapped.

Parameters:
- WAIT_CYCLES, 3, extra idle cycles inserted after the second halfword before completion; legal range 0..15.
- MEM_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  store request from the MEM stage, level, held until ready.
- rd_en  input  1  load request from the MEM stage, level, held until ready.
- address  input  32  byte address from the ALU result.
- write_data  input  32  store data (Val_Rm).
- read_data  output  32  load result, registered.
- ready  output  1  1 = no transaction pending or the transaction completes this cycle.
- sram_addr  output  18  SRAM halfword address.
- sram_dq_out  output  16  data driven toward the SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus.
- sram_dq_in  input  16  data read from the SRAM bus.
- sram_we_n  output  1  SRAM write enable, active low.

Behaviour:
- Reset values: state IDLE, wait counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1. Internal op/addr/data latches are 0.
- Word index: w = (address - MEM_BASE) >> 2, truncated to 17 bits. The low halfword address is {w,0} and the high halfword address is {w,1}.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when rd_en=0 and wr_en=0.
  - 0 in every other case, including the IDLE cycle in which a request first appears.
- State IDLE:
  - On (rd_en|wr_en), latch the operation, w and write_data, then go to LOW.
  - If both rd_en and wr_en are high, the write wins and the read is ignored.
- State LOW:
  - sram_addr={w,0}.
  - Write: sram_dq_oe=1, sram_dq_out=data[15:0], sram_we_n=0.
  - Read: sram_dq_oe=0, sram_we_n=1, and read_data[15:0] is captured from sram_dq_in at the closing edge.
  - Next state is HIGH.
- State HIGH:
  - Same as LOW, using {w,1} and data[31:16].
  - On a read, read_data[31:16] is captured at the closing edge.
  - Next state is WAIT, or DONE if WAIT_CYCLES=0.
- State WAIT:
  - sram_we_n=1, sram_dq_oe=0.
  - The counter increments each cycle.
  - Exit to DONE after exactly WAIT_CYCLES cycles; the counter clears on exit.
- State DONE:
  - ready=1 and read_data is stable and valid.
  - Next state is always IDLE. A request still high in the following IDLE cycle is treated as a new transaction; the pipeline must have advanced.
- Latency: with the request first seen in cycle 0, ready is 0 in cycles 0..(2+WAIT_CYCLES) and 1 in cycle 3+WAIT_CYCLES. That is 6 cycles at the default.
- Request dropped mid-transaction: the latched transaction still completes. No abort.
- Inputs changing mid-transaction: ignored, because latched values are used.
- read_data is updated only by reads. Writes leave it unchanged.
- sram_we_n is never low outside LOW and HIGH of a write.
- sram_dq_oe is never 1 during a read.
- rst in any state: return to IDLE the next edge with reset values. A partial SRAM write is allowed; no recovery is performed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, requests 0 -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store: wr_en=1, address=1028, write_data=0xDEADBEEF, held until ready.
  - Cycle 1: sram_addr=2, dq_out=0xBEEF, we_n=0.
  - Cycle 2: sram_addr=3, dq_out=0xDEAD, we_n=0.
  - ready=1 first in cycle 6.
- Load back: SRAM model holds addr2=0xBEEF, addr3=0xDEAD; rd_en=1, address=1028 -> read_data=0xDEADBEEF when ready rises in cycle 6, sram_we_n=1 throughout.
- Simultaneous rd_en=wr_en=1, address=1024, write_data=0x12345678 -> only a write occurs (addr0=0x5678, addr1=0x1234) and read_data is unchanged.
- WAIT_CYCLES=0 instance: rd_en at cycle 0 -> ready=0 in cycles 0..2, ready=1 in cycle 3.
- Reset mid-write: rst asserted during HIGH -> next cycle state IDLE, sram_we_n=1, dq_oe=0; a new rd_en request then completes with normal 6-cycle latency.
